// File: rtl/gray_ptr_decoder.sv
// gray_ptr_decoder
//
// Brings a reflected-binary gray pointer from another clock domain into the
// clk domain, decodes it to binary and watches how far the pointer moves on
// each sample. An advance larger than MAX_STEP usually means the source
// pointer was sampled mid-transition or the producer misbehaved. Such an
// advance raises a one-cycle step_err pulse, a sticky error flag and
// (optionally) a saturating error counter.
//
// Parameters:
//   W            gray/binary pointer width (2..16)
//   SYNC_STAGES  synchronizer flops on gray_in (0..4, 0 = already in clk domain)
//   MAX_STEP     largest legal forward advance per sample (1..2^W-1)
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous active-high reset
//   gray_in     gray pointer from the foreign domain
//   err_clr     synchronous clear of err_sticky and err_cnt
//   bin_out     registered binary decode of the synchronized pointer
//   bin_valid   bin_out holds a decoded sample
//   delta       registered forward distance (bin_out - previous bin_out) mod 2^W
//   step_err    one-cycle pulse aligned with the sample whose delta > MAX_STEP
//   err_sticky  set by step_err, held until err_clr or reset
//   err_cnt     saturating count of step_err pulses
//
// Configuration macro:
//   GRAYDEC_ERRCNT_EN  when defined, err_cnt is a real saturating counter;
//                      when undefined, err_cnt is tied to 0 and has no flops.

module gray_ptr_decoder #(
  parameter int W           = 5,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] bin_out,
  output logic         bin_valid,
  output logic [W-1:0] delta,
  output logic         step_err,
  output logic         err_sticky,
  output logic [7:0]   err_cnt
);

  localparam logic [W-1:0] MAX_STEP_W = W'(MAX_STEP);

  logic [W-1:0] sync_gray;
  logic         pre_valid;
  logic [W-1:0] bin_dec;
  logic [W-1:0] diff;

  // pre_valid runs alongside the sync chain. It marks the cycle in which
  // sync_gray carries a sample captured after reset, so that bin_valid
  // rises together with the first real decode.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_gray = gray_in;
      assign pre_valid = 1'b1;
    end else begin : g_sync
      logic [W-1:0]           chain [SYNC_STAGES];
      logic [SYNC_STAGES-1:0] vpipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
          vpipe <= '0;
        end else begin
          chain[0] <= gray_in;
          vpipe[0] <= 1'b1;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
            vpipe[i] <= vpipe[i-1];
          end
        end
      end

      assign sync_gray = chain[SYNC_STAGES-1];
      assign pre_valid = vpipe[SYNC_STAGES-1];
    end
  endgenerate

  // Binary bit i is the XOR of all gray bits from i upward. This is the same
  // chain as bin[i] = bin[i+1] ^ g[i], written without a self-referencing
  // vector.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < W; i++) begin
      bin_dec[i] = ^(sync_gray >> i);
    end
  end

  // Modular subtraction gives the forward distance, so a wrap from 2^W-1 to
  // 0 naturally reads as 1.
  assign diff = bin_dec - bin_out;

  // The decode register and the step check. A distance is only meaningful
  // when the previous bin_out was itself a valid sample. Otherwise this is
  // the first sample after reset, and delta is forced to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_out   <= '0;
      bin_valid <= 1'b0;
      delta     <= '0;
      step_err  <= 1'b0;
    end else begin
      bin_out   <= bin_dec;
      bin_valid <= pre_valid;
      if (pre_valid && bin_valid) begin
        delta    <= diff;
        step_err <= (diff > MAX_STEP_W);
      end else begin
        delta    <= '0;
        step_err <= 1'b0;
      end
    end
  end

  // The sticky flag follows the registered step_err pulse. A set wins over
  // a clear arriving in the same cycle, so no error is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
    end else if (step_err) begin
      err_sticky <= 1'b1;
    end else if (err_clr) begin
      err_sticky <= 1'b0;
    end
  end

`ifdef GRAYDEC_ERRCNT_EN
  // A clear that coincides with an error restarts the count at 1, so that
  // error is still counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= 8'd0;
    end else if (err_clr) begin
      err_cnt <= step_err ? 8'd1 : 8'd0;
    end else if (step_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// tb_gray_ptr_decoder
//
// Directed bench for gray_ptr_decoder at W=5, SYNC_STAGES=2, MAX_STEP=4.
// Inputs change 1 time unit after a rising edge. Outputs are examined at the
// same point, which is well clear of the next edge.
// Expected err_cnt values follow GRAYDEC_ERRCNT_EN: counts when the macro is
// defined, 0 when it is not.

module tb_gray_ptr_decoder;

  localparam int W           = 5;
  localparam int SYNC_STAGES = 2;
  localparam int MAX_STEP    = 4;

`ifdef GRAYDEC_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] gray_in = '0;
  logic         err_clr = 1'b0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic [W-1:0] delta;
  logic         step_err;
  logic         err_sticky;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  gray_ptr_decoder #(
    .W(W),
    .SYNC_STAGES(SYNC_STAGES),
    .MAX_STEP(MAX_STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .gray_in(gray_in),
    .err_clr(err_clr),
    .bin_out(bin_out),
    .bin_valid(bin_valid),
    .delta(delta),
    .step_err(step_err),
    .err_sticky(err_sticky),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Binary-to-gray encoding.
  function automatic logic [W-1:0] gray(input int b);
    logic [W-1:0] v;
    v = W'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds reset over two edges with gray_in preset, then releases it just
  // after an edge. The next edge is the first one out of reset.
  task automatic do_reset(input logic [W-1:0] g);
    reset   = 1'b1;
    err_clr = 1'b0;
    gray_in = g;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp_cnt;
    exp_cnt = 8'd0;
    reset   = 1'b1;
    gray_in = 5'b01000;
    step();
    step();
    checks++;
    if ({bin_out, bin_valid, delta, step_err, err_sticky, err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got bin=%0d v=%0b d=%0d se=%0b st=%0b cnt=%0d, expected all 0",
               bin_out, bin_valid, delta, step_err, err_sticky, err_cnt);
    end
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (bin_valid !== (c == 3)) begin
        errors++;
        $display("[TB] FAIL reset_valid_cycle%0d: got %0b expected %0b", c, bin_valid, (c == 3));
      end
    end
    checks++;
    if (bin_out !== 5'd15) begin
      errors++;
      $display("[TB] FAIL reset_first_bin: got %0d expected 15", bin_out);
    end
    checks++;
    if (delta !== 5'd0 || step_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_first_delta: got d=%0d se=%0b expected d=0 se=0", delta, step_err);
    end
    step();
    checks++;
    if (bin_out !== 5'd15 || delta !== 5'd0 || step_err !== 1'b0 || err_cnt !== exp_cnt) begin
      errors++;
      $display("[TB] FAIL reset_hold: got bin=%0d d=%0d se=%0b cnt=%0d expected 15 0 0 0",
               bin_out, delta, step_err, err_cnt);
    end
  endtask

  task automatic test_walk();
    int exp_bin;
    int exp_delta;
    do_reset(gray(0));
    for (int c = 0; c < 5; c++) step();
    for (int j = 1; j <= 36; j++) begin
      gray_in = gray(j % 32);
      step();
      exp_bin   = (j >= 3) ? ((j - 2) % 32) : 0;
      exp_delta = (j >= 3) ? 1 : 0;
      checks++;
      if (bin_out !== W'(exp_bin) || delta !== W'(exp_delta) || step_err !== 1'b0 || bin_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL walk_%0d: got bin=%0d d=%0d se=%0b v=%0b expected bin=%0d d=%0d se=0 v=1",
                 j, bin_out, delta, step_err, bin_valid, exp_bin, exp_delta);
      end
    end
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL walk_sticky: got %0b expected 0", err_sticky);
    end
  endtask

  task automatic test_jump();
    do_reset(gray(3));
    for (int c = 0; c < 5; c++) step();
    gray_in = gray(10);
    for (int c = 1; c <= 2; c++) begin
      step();
      checks++;
      if (step_err !== 1'b0 || bin_out !== 5'd3) begin
        errors++;
        $display("[TB] FAIL jump_pre%0d: got bin=%0d se=%0b expected bin=3 se=0", c, bin_out, step_err);
      end
    end
    step();
    checks++;
    if (bin_out !== 5'd10 || delta !== 5'd7 || step_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jump_hit: got bin=%0d d=%0d se=%0b expected bin=10 d=7 se=1", bin_out, delta, step_err);
    end
    step();
    checks++;
    if (step_err !== 1'b0 || delta !== 5'd0 || err_sticky !== 1'b1 || err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("[TB] FAIL jump_after: got se=%0b d=%0d st=%0b cnt=%0d expected se=0 d=0 st=1 cnt=%0d",
               step_err, delta, err_sticky, err_cnt, (CNT_EN ? 1 : 0));
    end
    for (int c = 0; c < 3; c++) step();
    checks++;
    if (err_sticky !== 1'b1 || step_err !== 1'b0 || err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("[TB] FAIL jump_held: got st=%0b se=%0b cnt=%0d expected st=1 se=0 cnt=%0d",
               err_sticky, step_err, err_cnt, (CNT_EN ? 1 : 0));
    end
  endtask

  task automatic test_saturate();
    do_reset(gray(0));
    for (int c = 0; c < 5; c++) step();
    for (int k = 1; k <= 300; k++) begin
      gray_in = gray((8 * k) % 32);
      step();
      if (k == 10) begin
        checks++;
        if (step_err !== 1'b1 || delta !== 5'd8) begin
          errors++;
          $display("[TB] FAIL sat_midstream: got se=%0b d=%0d expected se=1 d=8", step_err, delta);
        end
      end
    end
    for (int c = 0; c < 5; c++) step();
    checks++;
    if (err_cnt !== (CNT_EN ? 8'd255 : 8'd0) || err_sticky !== 1'b1 || step_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_count: got cnt=%0d st=%0b se=%0b expected cnt=%0d st=1 se=0",
               err_cnt, err_sticky, step_err, (CNT_EN ? 255 : 0));
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL clr_only: got st=%0b cnt=%0d expected st=0 cnt=0", err_sticky, err_cnt);
    end
    gray_in = gray(8);
    step();
    step();
    step();
    checks++;
    if (step_err !== 1'b1 || delta !== 5'd8) begin
      errors++;
      $display("[TB] FAIL clr_coinc_pulse: got se=%0b d=%0d expected se=1 d=8", step_err, delta);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (err_sticky !== 1'b1 || err_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
      errors++;
      $display("[TB] FAIL clr_coinc: got st=%0b cnt=%0d expected st=1 cnt=%0d",
               err_sticky, err_cnt, (CNT_EN ? 1 : 0));
    end
  endtask

  task automatic test_midreset();
    do_reset(gray(0));
    for (int c = 0; c < 5; c++) step();
    for (int j = 1; j <= 22; j++) begin
      gray_in = gray(j);
      step();
    end
    checks++;
    if (bin_out !== 5'd20 || delta !== 5'd1) begin
      errors++;
      $display("[TB] FAIL mid_prereset: got bin=%0d d=%0d expected bin=20 d=1", bin_out, delta);
    end
    #2;
    reset   = 1'b1;
    gray_in = gray(2);
    #1;
    checks++;
    if ({bin_out, bin_valid, delta, step_err, err_sticky, err_cnt} !== '0) begin
      errors++;
      $display("[TB] FAIL mid_async_reset: got bin=%0d v=%0b d=%0d se=%0b st=%0b cnt=%0d expected all 0",
               bin_out, bin_valid, delta, step_err, err_sticky, err_cnt);
    end
    step();
    step();
    reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (bin_valid !== (c == 3)) begin
        errors++;
        $display("[TB] FAIL mid_valid_cycle%0d: got %0b expected %0b", c, bin_valid, (c == 3));
      end
    end
    checks++;
    if (bin_out !== 5'd2 || delta !== 5'd0 || step_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_first: got bin=%0d d=%0d se=%0b expected bin=2 d=0 se=0", bin_out, delta, step_err);
    end
    step();
    checks++;
    if (step_err !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_no_err: got se=%0b st=%0b expected 0 0", step_err, err_sticky);
    end
  endtask

  initial begin
    $display("[TB] gray_ptr_decoder bench, counter build = %0b", CNT_EN);
    test_reset();
    test_walk();
    test_jump();
    test_saturate();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
